// File: rtl/cc_data_delay_line.sv
// Multi-stage data delay line with run-time tap select.
// Samples advance on a shift strobe (level or edge); valid tracks tap fill.
module cc_data_delay_line #(
  parameter int DATAWIDTH_BUS  = 8,
  parameter int DEPTH_MAX      = 8,
  parameter int DELAYSEL_WIDTH = 4,
  parameter int SHIFT_MODE     = 0
) (
  input  logic                      CC_DATADELAYLINE_CLOCK_50,
  input  logic                      CC_DATADELAYLINE_RESET_InHigh,
  input  logic [DATAWIDTH_BUS-1:0]  CC_DATADELAYLINE_Data_inBus,
  input  logic                      CC_DATADELAYLINE_SendDataSignal_In,
  input  logic [DELAYSEL_WIDTH-1:0] CC_DATADELAYLINE_DelaySel_InBus,
  input  logic                      CC_DATADELAYLINE_Flush_In,
  output logic [DATAWIDTH_BUS-1:0]  CC_DATADELAYLINE_DelayedData_outBus,
  output logic                      CC_DATADELAYLINE_Valid_Out
);

  localparam int FILL_W = $clog2(DEPTH_MAX + 1);

  logic [DATAWIDTH_BUS-1:0]  stage_q [DEPTH_MAX];
  logic [DATAWIDTH_BUS-1:0]  stage_d [DEPTH_MAX];
  logic [FILL_W-1:0]         fill_q;
  logic [FILL_W-1:0]         fill_d;
  logic                      strobe_q;
  logic                      strobe_d;
  logic                      shift_ev;
  logic [DELAYSEL_WIDTH-1:0] neff;

  always_comb begin
    shift_ev = CC_DATADELAYLINE_SendDataSignal_In;
    if (SHIFT_MODE == 1) begin
      shift_ev = CC_DATADELAYLINE_SendDataSignal_In & ~strobe_q;
    end
  end

  // Out-of-range selects clamp to the nearest real tap.
  always_comb begin
    neff = CC_DATADELAYLINE_DelaySel_InBus;
    if (CC_DATADELAYLINE_DelaySel_InBus == '0) begin
      neff = DELAYSEL_WIDTH'(1);
    end else if (CC_DATADELAYLINE_DelaySel_InBus >
                 DELAYSEL_WIDTH'(DEPTH_MAX)) begin
      neff = DELAYSEL_WIDTH'(DEPTH_MAX);
    end
  end

  always_comb begin
    strobe_d = CC_DATADELAYLINE_SendDataSignal_In;
    fill_d   = fill_q;
    for (int k = 0; k < DEPTH_MAX; k++) begin
      stage_d[k] = stage_q[k];
    end
    if (CC_DATADELAYLINE_Flush_In) begin
      strobe_d = 1'b0;
      fill_d   = '0;
      for (int k = 0; k < DEPTH_MAX; k++) begin
        stage_d[k] = '0;
      end
    end else if (shift_ev) begin
      stage_d[0] = CC_DATADELAYLINE_Data_inBus;
      for (int k = 1; k < DEPTH_MAX; k++) begin
        stage_d[k] = stage_q[k-1];
      end
      if (fill_q != FILL_W'(DEPTH_MAX)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge CC_DATADELAYLINE_CLOCK_50) begin
    if (CC_DATADELAYLINE_RESET_InHigh) begin
      strobe_q <= 1'b0;
      fill_q   <= '0;
      for (int k = 0; k < DEPTH_MAX; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      strobe_q <= strobe_d;
      fill_q   <= fill_d;
      for (int k = 0; k < DEPTH_MAX; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  always_comb begin
    CC_DATADELAYLINE_DelayedData_outBus = '0;
    for (int k = 0; k < DEPTH_MAX; k++) begin
      if (neff == DELAYSEL_WIDTH'(k + 1)) begin
        CC_DATADELAYLINE_DelayedData_outBus = stage_q[k];
      end
    end
  end

  assign CC_DATADELAYLINE_Valid_Out = 32'(fill_q) >= 32'(neff);

endmodule

// File: tb/tb_cc_data_delay_line.sv
// Bench for cc_data_delay_line: level- and edge-mode instances
// checked against a queue-style reference model.
module tb_cc_data_delay_line;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       strobe;
  logic [3:0] sel;
  logic       flush;
  logic [7:0] dout0, dout1;
  logic       vld0, vld1;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] m_stage [2][8];
  int         m_fill  [2];
  bit         m_prev  [2];

  always #5 clk = ~clk;

  cc_data_delay_line #(
    .DATAWIDTH_BUS(8), .DEPTH_MAX(8),
    .DELAYSEL_WIDTH(4), .SHIFT_MODE(0)
  ) dut0 (
    .CC_DATADELAYLINE_CLOCK_50          (clk),
    .CC_DATADELAYLINE_RESET_InHigh      (rst),
    .CC_DATADELAYLINE_Data_inBus        (din),
    .CC_DATADELAYLINE_SendDataSignal_In (strobe),
    .CC_DATADELAYLINE_DelaySel_InBus    (sel),
    .CC_DATADELAYLINE_Flush_In          (flush),
    .CC_DATADELAYLINE_DelayedData_outBus(dout0),
    .CC_DATADELAYLINE_Valid_Out         (vld0)
  );

  cc_data_delay_line #(
    .DATAWIDTH_BUS(8), .DEPTH_MAX(8),
    .DELAYSEL_WIDTH(4), .SHIFT_MODE(1)
  ) dut1 (
    .CC_DATADELAYLINE_CLOCK_50          (clk),
    .CC_DATADELAYLINE_RESET_InHigh      (rst),
    .CC_DATADELAYLINE_Data_inBus        (din),
    .CC_DATADELAYLINE_SendDataSignal_In (strobe),
    .CC_DATADELAYLINE_DelaySel_InBus    (sel),
    .CC_DATADELAYLINE_Flush_In          (flush),
    .CC_DATADELAYLINE_DelayedData_outBus(dout1),
    .CC_DATADELAYLINE_Valid_Out         (vld1)
  );

  function automatic int neff_of(input logic [3:0] s);
    if (s == 0) return 1;
    if (s > 8) return 8;
    return int'(s);
  endfunction

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      bit ev;
      if (rst || flush) begin
        for (int k = 0; k < 8; k++) m_stage[i][k] = 8'h00;
        m_fill[i] = 0;
        m_prev[i] = 1'b0;
      end else begin
        ev = (i == 0) ? strobe : (strobe && !m_prev[i]);
        if (ev) begin
          for (int k = 7; k > 0; k--) m_stage[i][k] = m_stage[i][k-1];
          m_stage[i][0] = din;
          if (m_fill[i] < 8) m_fill[i]++;
        end
        m_prev[i] = strobe;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = neff_of(sel);
    chk({tag, "/dout0"}, dout0, m_stage[0][n-1]);
    chk({tag, "/vld0"}, {7'b0, vld0}, {7'b0, m_fill[0] >= n});
    chk({tag, "/dout1"}, dout1, m_stage[1][n-1]);
    chk({tag, "/vld1"}, {7'b0, vld1}, {7'b0, m_fill[1] >= n});
  endtask

  task automatic cyc(input bit r, input bit s, input logic [7:0] d,
                     input logic [3:0] sv, input bit f, input string tag);
    rst = r; strobe = s; din = d; sel = sv; flush = f;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; strobe = 1'b0; din = 8'h00; sel = 4'd3; flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 8; k++) m_stage[i][k] = 8'h00;
      m_fill[i] = 0;
      m_prev[i] = 1'b0;
    end

    cyc(1, 0, 8'h00, 3, 0, "reset");
    chk("reset_lit_dout", dout0, 8'h00);
    chk("reset_lit_vld", {7'b0, vld0}, 8'h00);

    cyc(0, 1, 8'h11, 3, 0, "t1_e1"); cyc(0, 0, 8'h99, 3, 0, "t1_g1");
    cyc(0, 1, 8'h22, 3, 0, "t1_e2"); cyc(0, 0, 8'h99, 3, 0, "t1_g2");
    cyc(0, 1, 8'h33, 3, 0, "t1_e3");
    chk("t1_lit_11", dout0, 8'h11);
    cyc(0, 0, 8'h99, 3, 0, "t1_g3");
    cyc(0, 1, 8'h44, 3, 0, "t1_e4");
    chk("t1_lit_22", dout0, 8'h22);

    cyc(1, 1, 8'hA5, 1, 0, "t2_rst_strobe_high");
    for (int c = 0; c < 5; c++) cyc(0, 1, 8'hA5, 1, 0, "t2_hold");
    cyc(0, 0, 8'h5A, 1, 0, "t2_low");
    chk("t2_lit_dout1", dout1, 8'hA5);
    chk("t2_lit_vld1", {7'b0, vld1}, 8'h01);

    cyc(1, 0, 8'h00, 1, 0, "t3_rst");
    for (int v = 1; v <= 8; v++) begin
      cyc(0, 1, 8'(v), 1, 0, "t3_fill");
      cyc(0, 0, 8'hEE, 1, 0, "t3_gap");
    end
    for (int s = 0; s < 16; s++) cyc(0, 0, 8'hEE, 4'(s), 0, "t3_sweep");
    chk("t3_lit_sel15", dout1, 8'h01);

    cyc(1, 0, 8'h00, 2, 0, "t4_rst");
    cyc(0, 1, 8'hC1, 2, 0, "t4_e1"); cyc(0, 0, 8'h00, 2, 0, "t4_g1");
    cyc(0, 1, 8'hC2, 2, 0, "t4_e2"); cyc(0, 0, 8'h00, 2, 0, "t4_g2");
    sel = 4'd5;
    #1;
    check_all("t4_sel_change");
    for (int e = 0; e < 3; e++) begin
      cyc(0, 1, 8'(8'hD0 + e), 5, 0, "t4_more");
      cyc(0, 0, 8'h00, 5, 0, "t4_gap");
    end
    chk("t4_lit_first", dout0, 8'hC1);

    cyc(0, 1, 8'hFF, 1, 1, "t5_flush");
    chk("t5_lit_flush_vld", {7'b0, vld0}, 8'h00);
    cyc(0, 0, 8'h00, 1, 0, "t5_after");
    cyc(0, 1, 8'h3C, 1, 0, "t5_refill"); cyc(0, 0, 8'h00, 1, 0, "t5_gap");
    cyc(1, 1, 8'hFF, 1, 0, "t5_midrst");

    cyc(1, 0, 8'h00, 8, 0, "t6_rst");
    for (int c = 0; c < 20; c++) cyc(0, 1, 8'(c + 1), 8, 0, "t6_stream");
    chk("t6_lit_dout0", dout0, 8'd13);

    for (int c = 0; c < 300; c++) begin
      cyc(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1,
          8'($urandom), 4'($urandom), ($urandom_range(0, 15) == 0),
          "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/cc_data_delay_line.md
Name: cc_data_delay_line

Overview:
- Parametrised, clocked, multi-stage data delay line. Successor to the single-stage strobe-driven delay.
- Holds up to DEPTH_MAX samples in a shift register that advances on a shift strobe.
- Run-time delay select picks the output tap; a valid flag indicates that the selected tap holds real data.
- Sits between game-logic producers (e.g. sprite/position buses) and consumers that need data aligned N events later.

Parameters:
- DATAWIDTH_BUS, 8, width of data in/out.
- DEPTH_MAX, 8, number of storage stages (≥2).
- DELAYSEL_WIDTH, 4, width of delay-select input; must satisfy 2^DELAYSEL_WIDTH > DEPTH_MAX.
- SHIFT_MODE, 0, 0 = shift every clock while strobe high (level); 1 = shift once per rising edge of strobe (edge).

Ports:
- CC_DATADELAYLINE_CLOCK_50  in  1  system clock; all state updates on rising edge.
- CC_DATADELAYLINE_RESET_InHigh  in  1  synchronous, active-high reset.
- CC_DATADELAYLINE_Data_inBus  in  DATAWIDTH_BUS  sample to insert.
- CC_DATADELAYLINE_SendDataSignal_In  in  1  shift strobe (level or edge per SHIFT_MODE).
- CC_DATADELAYLINE_DelaySel_InBus  in  DELAYSEL_WIDTH  requested delay N, in shift events.
- CC_DATADELAYLINE_Flush_In  in  1  synchronous clear of stored samples.
- CC_DATADELAYLINE_DelayedData_outBus  out  DATAWIDTH_BUS  sample from tap N.
- CC_DATADELAYLINE_Valid_Out  out  1  high when tap N has been written since last reset/flush.

Behaviour:
- Shift event (SHIFT_EV):
  - SHIFT_MODE=0: SHIFT_EV = strobe.
  - SHIFT_MODE=1: SHIFT_EV = strobe & ~strobe_q. strobe_q is registered, resets to 0, and is also cleared by flush.
  - Strobe already high at the first clock after reset in mode 1 produces exactly one event.
- Storage: stage[0..DEPTH_MAX-1].
  - On SHIFT_EV: stage[0] <= Data_inBus; stage[k] <= stage[k-1].
  - No SHIFT_EV: hold.
- Effective delay Neff:
  - Neff = 1 if DelaySel = 0.
  - Neff = DEPTH_MAX if DelaySel > DEPTH_MAX.
  - Otherwise Neff = DelaySel.
- Output: DelayedData_outBus = stage[Neff-1], a combinational mux of registered stages.
  - Sample captured at shift event k appears at the output in the cycle after shift event k+Neff-1, i.e. after Neff events.
  - Clock latency from a strobe to the output update is 1 cycle.
- Fill counter (width ≥ clog2(DEPTH_MAX+1)):
  - Increments on SHIFT_EV and saturates at DEPTH_MAX.
  - Valid_Out = (fill >= Neff), combinational.
- DelaySel changes take effect in the same cycle; no re-fill is required if fill ≥ new Neff.
- Reset (highest priority):
  - All stages = 0, fill = 0, strobe_q = 0.
  - DelayedData_outBus = 0, Valid_Out = 0.
  - Reset mid-stream discards all contents.
- Flush: identical effect to reset on the next edge.
  - Flush wins over a simultaneous SHIFT_EV; the incoming sample is dropped.
- Saturation: shifting when full discards stage[DEPTH_MAX-1]; fill stays DEPTH_MAX, no error flag.
- Data is not sampled when there is no SHIFT_EV; input changes between events are ignored.

Test Plan:
- Reset, then SHIFT_MODE=0, DelaySel=3, strobe high 1 cycle each with data 0x11,0x22,0x33,0x44 -> Valid rises after 3rd event; output 0x11 then 0x22 after 4th event; before that output=0x00, Valid=0.
- SHIFT_MODE=1, strobe held high 5 cycles with data 0xA5 then low -> exactly one shift; fill=1; DelaySel=1 gives output 0xA5, Valid=1.
- Fill all 8 stages with 0x01..0x08; sweep DelaySel 1..8 -> outputs 0x08..0x01, Valid=1 throughout; DelaySel=0 -> 0x08; DelaySel=15 -> 0x01.
- After 2 events with DelaySel=2 (Valid=1), change DelaySel to 5 -> Valid drops same cycle; 3 more events -> Valid=1 and output = first sample.
- Flush asserted with a simultaneous strobe and data 0xFF -> next cycle all outputs 0, Valid=0, 0xFF not stored; a mid-stream Reset_InHigh behaves identically.
- Continuous strobe for 20 cycles, incrementing data, DelaySel=8 -> output equals input from 8 events earlier; fill saturates at 8; no X on outputs.
